// File: rtl/node_pkg.sv
// node_pkg
// Shared constants and types for the neighbour-scan controller.
//   KEY_W   : width of one node / neighbour value
//   state_t : scan controller FSM states
package node_pkg;

    localparam int KEY_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/node_scan_ctrl_eq2_cmp.sv
// eq2_cmp
// Combinational equality comparator for one key-width value.
// Ports:
//   i_a, i_b : values to compare
//   o_eq     : 1 when i_a equals i_b
module eq2_cmp
    import node_pkg::*;
(
    input  logic [KEY_W-1:0] i_a,
    input  logic [KEY_W-1:0] i_b,
    output logic             o_eq
);

    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/node_scan_ctrl.sv
// node_scan_ctrl
// Serially compares a captured key against NBR captured neighbour slots,
// one slot per clock, through a single shared comparator.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a scan (only honoured in IDLE)
//   abort       : cancel a scan in progress, clearing all results
//   key_in      : node value to match
//   nbr_in      : flattened neighbour values, slot i at [2i+1:2i]
//   busy        : high while scanning or in the done cycle
//   done        : one-cycle pulse when results are final
//   match       : any recorded slot matched
//   match_mask  : per-slot match bits
//   match_cnt   : number of matching slots
//   first_idx   : lowest matching slot (0 if none)
module node_scan_ctrl
    import node_pkg::*;
#(
    parameter int NBR        = 4,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [KEY_W-1:0]           key_in,
    input  logic [KEY_W*NBR-1:0]       nbr_in,
    output logic                       busy,
    output logic                       done,
    output logic                       match,
    output logic [NBR-1:0]             match_mask,
    output logic [$clog2(NBR+1)-1:0]   match_cnt,
    output logic [$clog2(NBR)-1:0]     first_idx
);

    localparam int IDX_W = $clog2(NBR);
    localparam int CNT_W = $clog2(NBR+1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   r_slot [NBR];
    logic               r_busy;
    logic               r_done;
    logic               r_match;
    logic [NBR-1:0]     r_mask;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_first;

    logic [KEY_W-1:0]   w_slot;
    logic               w_eq;
    logic               w_last;
    logic               w_stop;

    // The slot under test is selected from the captured copy, so later
    // changes on nbr_in cannot disturb a scan in flight.
    assign w_slot = r_slot[r_idx];
    assign w_last = (r_idx == IDX_W'(NBR-1));
    assign w_stop = w_last || (EARLY_EXIT && w_eq);

    eq2_cmp u_cmp (
        .i_a  (w_slot),
        .i_b  (r_key),
        .o_eq (w_eq)
    );

    // Scan FSM with all outputs registered. Abort is tested before any
    // scan progress so it beats a scan completing on the same edge, and
    // in IDLE it also vetoes a simultaneous start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_key   <= '0;
            for (int i = 0; i < NBR; i++) r_slot[i] <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_first <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_key <= key_in;
                        for (int i = 0; i < NBR; i++)
                            r_slot[i] <= nbr_in[i*KEY_W +: KEY_W];
                        r_idx   <= '0;
                        r_match <= 1'b0;
                        r_mask  <= '0;
                        r_cnt   <= '0;
                        r_first <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        r_idx   <= '0;
                        r_match <= 1'b0;
                        r_mask  <= '0;
                        r_cnt   <= '0;
                        r_first <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_mask[r_idx] <= w_eq;
                        r_idx         <= r_idx + IDX_W'(1);
                        if (w_eq) begin
                            r_match <= 1'b1;
                            if (r_cnt != CNT_W'(NBR))
                                r_cnt <= r_cnt + CNT_W'(1);
                            // Only the first hit sets the lowest index.
                            if (!r_match)
                                r_first <= r_idx;
                        end
                        if (w_stop) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        r_idx   <= '0;
                        r_match <= 1'b0;
                        r_mask  <= '0;
                        r_cnt   <= '0;
                        r_first <= '0;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign match      = r_match;
    assign match_mask = r_mask;
    assign match_cnt  = r_cnt;
    assign first_idx  = r_first;

endmodule

// File: tb/tb_node_scan_ctrl.sv
// tb_node_scan_ctrl
// Drives a full-scan and an early-exit instance from the same inputs and
// checks both against a per-scan result model every cycle, plus literal
// expectations for the reference scenarios.
module tb_node_scan_ctrl;

    localparam int NBR = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       key_in = '0;
    logic [2*NBR-1:0] nbr_in = '0;

    logic             busyO  [2];
    logic             doneO  [2];
    logic             matchO [2];
    logic [NBR-1:0]   maskO  [2];
    logic [2:0]       cntO   [2];
    logic [1:0]       firstO [2];

    int passCount  = 0;
    int checkCount = 0;
    int doneCount0 = 0;
    int doneCount1 = 0;

    // Model: per instance, the full match vector captured at accept, the
    // scan length, and how many edges have elapsed since accept.
    bit             mActive [2] = '{0, 0};
    int             mK      [2] = '{0, 0};
    int             mL      [2] = '{0, 0};
    logic [NBR-1:0] mFull   [2] = '{'0, '0};
    logic           mBusy   [2] = '{0, 0};
    logic           mDone   [2] = '{0, 0};
    logic           mMatch  [2] = '{0, 0};
    logic [NBR-1:0] mMask   [2] = '{'0, '0};
    int             mCnt    [2] = '{0, 0};
    int             mFirst  [2] = '{0, 0};

    node_scan_ctrl #(.NBR(NBR), .EARLY_EXIT(1'b0)) dutFull (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .key_in(key_in), .nbr_in(nbr_in),
        .busy(busyO[0]), .done(doneO[0]), .match(matchO[0]),
        .match_mask(maskO[0]), .match_cnt(cntO[0]), .first_idx(firstO[0])
    );

    node_scan_ctrl #(.NBR(NBR), .EARLY_EXIT(1'b1)) dutEarly (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .key_in(key_in), .nbr_in(nbr_in),
        .busy(busyO[1]), .done(doneO[1]), .match(matchO[1]),
        .match_mask(maskO[1]), .match_cnt(cntO[1]), .first_idx(firstO[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    endtask

    // Results after k slots have been examined: the captured match vector
    // restricted to slots below k.
    function automatic void setResults(input int e, input int k);
        int m;
        m = int'(mFull[e]) & ((1 << k) - 1);
        mMask[e]  = m[NBR-1:0];
        mCnt[e]   = $countones(mMask[e]);
        mMatch[e] = |mMask[e];
        mFirst[e] = 0;
        for (int i = NBR-1; i >= 0; i--) if (mMask[e][i]) mFirst[e] = i;
    endfunction

    function automatic void stepModel(input int e);
        if (!mActive[e]) begin
            mDone[e] = 1'b0;
            if (start && !abort) begin
                for (int i = 0; i < NBR; i++) mFull[e][i] = (nbr_in[2*i +: 2] == key_in);
                mL[e] = NBR;
                if (e == 1)
                    for (int i = NBR-1; i >= 0; i--) if (mFull[e][i]) mL[e] = i + 1;
                mK[e] = 0;
                mActive[e] = 1'b1;
                mBusy[e] = 1'b1;
                setResults(e, 0);
            end else begin
                mBusy[e] = 1'b0;
            end
        end else if (abort) begin
            mActive[e] = 1'b0;
            mBusy[e] = 1'b0;
            mDone[e] = 1'b0;
            setResults(e, 0);
        end else if (mK[e] == mL[e]) begin
            mActive[e] = 1'b0;
            mBusy[e] = 1'b0;
            mDone[e] = 1'b0;
        end else begin
            mK[e]++;
            setResults(e, mK[e]);
            mDone[e] = (mK[e] == mL[e]);
            mBusy[e] = 1'b1;
        end
    endfunction

    // Model advances on the same edges as the DUT and resets with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                mActive[e] = 1'b0; mBusy[e] = 1'b0; mDone[e] = 1'b0;
                mFull[e] = '0; setResults(e, 0);
            end
        end else begin
            for (int e = 0; e < 2; e++) stepModel(e);
        end
    end

    // Per-cycle comparison of every output of both instances.
    always @(negedge clk) begin
        for (int e = 0; e < 2; e++) begin
            logic [1:0] expFirst;
            logic [2:0] expCnt;
            expFirst = mFirst[e][1:0];
            expCnt   = mCnt[e][2:0];
            checkOutput($sformatf("cycle_dut%0d", e),
                        {20'd0, busyO[e], doneO[e], matchO[e], maskO[e], cntO[e], firstO[e]},
                        {20'd0, mBusy[e], mDone[e], mMatch[e], mMask[e], expCnt, expFirst});
        end
        if (doneO[0]) doneCount0++;
        if (doneO[1]) doneCount1++;
    end

    function automatic logic [9:0] results(input int e);
        return {matchO[e], maskO[e], cntO[e], firstO[e]};
    endfunction

    task automatic applyStimulus(input logic s, input logic a, input logic [1:0] k,
                                 input logic [2*NBR-1:0] n);
        @(negedge clk);
        #1;
        start = s; abort = a; key_in = k; nbr_in = n;
    endtask

    // Launch one scan and measure, per instance, edges from accept to done.
    task automatic runScan(input logic [1:0] k, input logic [2*NBR-1:0] n,
                           output int lat0, output int lat1, output int busyCnt0);
        lat0 = -1; lat1 = -1; busyCnt0 = 0;
        applyStimulus(1'b1, 1'b0, k, n);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busyO[0]) busyCnt0++;
            if (doneO[0] && lat0 < 0) lat0 = i - 1;
            if (doneO[1] && lat1 < 0) lat1 = i - 1;
            if (lat0 >= 0 && lat1 >= 0) break;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int l0, l1, bc, d0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_state", {22'd0, results(0)}, 32'd0);

        // Reference: two matching slots, full and early-exit views.
        runScan(2'b01, 8'b01_00_01_11, l0, l1, bc);
        checkOutput("ref1_latency_full", l0, 4);
        checkOutput("ref1_busy_cycles", bc, 5);
        checkOutput("ref1_results_full", {22'd0, results(0)}, {22'd0, 10'b1_1010_010_01});
        checkOutput("ref1_model_mask", {28'd0, mMask[0]}, 32'b1010);
        checkOutput("ref1_latency_early", l1, 2);
        checkOutput("ref1_results_early", {22'd0, results(1)}, {22'd0, 10'b1_0010_001_01});

        // No matches anywhere: early exit must scan everything.
        runScan(2'b10, 8'b00_00_00_00, l0, l1, bc);
        checkOutput("nomatch_latency_full", l0, 4);
        checkOutput("nomatch_latency_early", l1, 4);
        checkOutput("nomatch_results", {22'd0, results(0), results(1)} , 32'd0);

        // Early exit on slot 1 with later slots also matching.
        runScan(2'b11, 8'b11_11_11_00, l0, l1, bc);
        checkOutput("early_latency", l1, 2);
        checkOutput("early_results", {22'd0, results(1)}, {22'd0, 10'b1_0010_001_01});
        checkOutput("early_model_cnt", mCnt[1], 1);
        checkOutput("early_full_results", {22'd0, results(0)}, {22'd0, 10'b1_1110_011_01});

        // Restart and input change mid-scan are ignored.
        d0 = doneCount0;
        applyStimulus(1'b1, 1'b0, 2'b01, 8'b01_00_01_11);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; nbr_in = 8'b01_01_01_01; key_in = 2'b00;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("restart_done_pulses", doneCount0 - d0, 1);
        checkOutput("restart_results", {22'd0, results(0)}, {22'd0, 10'b1_1010_010_01});

        // Abort on the second scan edge.
        d0 = doneCount0;
        applyStimulus(1'b1, 1'b0, 2'b01, 8'b01_00_01_11);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        checkOutput("abort_outputs", {21'd0, busyO[0], results(0)}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_no_done", doneCount0 - d0, 0);
        runScan(2'b01, 8'b01_00_01_11, l0, l1, bc);
        checkOutput("abort_fresh_latency", l0, 4);
        checkOutput("abort_fresh_results", {22'd0, results(0)}, {22'd0, 10'b1_1010_010_01});

        // Start with abort in IDLE: abort wins.
        applyStimulus(1'b1, 1'b1, 2'b00, 8'b00_00_00_00);
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        checkOutput("start_abort_idle_busy", {31'd0, busyO[0]}, 32'd0);

        // Asynchronous reset mid-scan.
        d0 = doneCount0;
        applyStimulus(1'b1, 1'b0, 2'b01, 8'b01_00_01_11);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {20'd0, busyO[0], doneO[0], results(0)}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("reset_no_done", doneCount0 - d0, 0);
        runScan(2'b00, 8'b00_00_00_00, l0, l1, bc);
        checkOutput("post_reset_full", {22'd0, results(0)}, {22'd0, 10'b1_1111_100_00});
        checkOutput("post_reset_early_latency", l1, 1);

        // Randomized traffic, checked every cycle by the model.
        repeat (400) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                          2'($urandom), 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00);
        repeat (8) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/node_scan_ctrl.md
NODE_SCAN_CTRL -- requirements
Module: node_scan_ctrl

Interface
REQ-001 Parameter NBR, default 4, sets the number of neighbour slots scanned (legal range 2..16).
REQ-002 Parameter EARLY_EXIT, default 0, selects stop-on-first-match (1) or full scan (0).
REQ-003 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request to begin a scan; honoured only in IDLE.
REQ-006 abort  input  1  cancels a scan in progress.
REQ-007 key_in  input  2  node value to be matched.
REQ-008 nbr_in  input  2*NBR  flattened neighbour values; slot i occupies bits [2i+1:2i].
REQ-009 busy  output  1  high while in SCAN or DONE.
REQ-010 done  output  1  one-cycle pulse marking that the results are final.
REQ-011 match  output  1  OR of all recorded slot matches.
REQ-012 match_mask  output  NBR  bit i set when slot i equals key.
REQ-013 match_cnt  output  clog2(NBR+1)  population count of match_mask.
REQ-014 first_idx  output  clog2(NBR)  lowest matching slot index; 0 when match=0.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-016 On an IDLE edge with start=1, the block SHALL capture key_in and nbr_in into internal registers, clear all result outputs, set idx=0 and enter SCAN.
REQ-017 In SCAN, each edge SHALL compare the captured slot idx against the captured key using the single comparator, record the result in match_mask[idx], then increment idx.
REQ-018 The block SHALL enter DONE on the edge that records slot NBR-1; it SHALL assert done for exactly that one DONE cycle, then return to IDLE.
REQ-019 Latency (EARLY_EXIT=0) SHALL be: start accepted at edge E0, done high in the cycle following edge E_NBR, busy high for NBR+1 cycles.
REQ-020 With EARLY_EXIT=1, the block SHALL enter DONE on the edge that records the first match; unscanned mask bits SHALL remain 0.
REQ-021 match, match_cnt and first_idx SHALL be updated incrementally each SCAN edge; match_cnt SHALL saturate at NBR and never wrap.
REQ-022 Result outputs SHALL hold their values in IDLE until the next accepted start.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 abort=1 in SCAN or DONE SHALL return the FSM to IDLE on the next edge, clear all results and suppress done.
REQ-025 abort takes priority over a scan completing on the same edge.
REQ-026 start and abort both high in IDLE: abort wins and the scan is not started.
REQ-027 Changes on key_in and nbr_in after capture SHALL NOT affect the scan in progress.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously force state=IDLE, idx=0, busy=0, done=0, match=0, match_mask=0, match_cnt=0 and first_idx=0.
REQ-029 Reset mid-scan SHALL discard the scan, and no done SHALL follow deassertion.
REQ-030 Reset deassertion is synchronous to clk at the integrating level; the block SHALL NOT start before the first start seen with rst_n=1.

Structure
REQ-031 Package node_pkg SHALL hold the KEY_W=2 constant and the state enum (IDLE, SCAN, DONE).
REQ-032 Sub-module eq2_cmp SHALL be a combinational 2-bit equality comparator with output 1 when equal, instantiated exactly once and fed by an idx-driven slot mux.
REQ-033 No combinational path SHALL exist from any input to done or busy.

Verification
REQ-034 NBR=4, key=2'b01, slots {0:11, 1:01, 2:00, 3:01}, start pulse -> done 4 cycles after accept; mask=4'b1010, cnt=2, first_idx=1, match=1.
REQ-035 key=2'b10, slots all 2'b00 -> done after 4 cycles; mask=0, cnt=0, match=0, first_idx=0.
REQ-036 EARLY_EXIT=1, key=2'b11, slots {0:00, 1:11, 2:11, 3:11} -> done 2 cycles after accept; mask=4'b0010, cnt=1, first_idx=1.
REQ-037 Start a scan, change nbr_in and pulse start again during SCAN -> results reflect the originally captured values; exactly one done pulse.
REQ-038 abort asserted on the 2nd SCAN edge -> IDLE on the next edge, outputs all 0, no done pulse; a fresh start afterwards completes normally.
REQ-039 rst_n low mid-scan -> outputs 0 immediately without waiting for clk; no done after release; key=2'b00 with all slots 2'b00 then gives cnt=4, mask=4'b1111.
